// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the memory-mapped 7-segment display controller:
// digit/control register field positions, bus data width and the
// hex-nibble to active-high segment table (bit 0 = segment a).
// ---------------------------------------------------------------------------
package seg7_pkg;

  localparam int DATA_W     = 9;

  // Digit register fields
  localparam int BLINK_BIT  = 8;
  localparam int HEX_BIT    = 7;
  localparam int SEG_MSB    = 6;
  localparam int NIBBLE_MSB = 3;

  // Control register fields
  localparam int CTRL_W         = 4;
  localparam int CTRL_BLANK_BIT = 0;
  localparam int CTRL_RATE_LSB  = 1;
  localparam int CTRL_RATE_MSB  = 3;

  typedef struct packed {
    logic [CTRL_RATE_MSB-CTRL_RATE_LSB:0] rate;
    logic                                 blank;
  } ctrl_t;

  // Active-high segments, bit order g..a
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_mmio_display_if.sv
// ---------------------------------------------------------------------------
// seg7_mmio_display_if
// Strobe/ack register bus between the processor (master) and the display
// controller (slave).
//   sel     : write strobe, one-cycle pulse qualified by addr/data
//   addr    : register address (digits 0..NUM_DIGITS-1, control = NUM_DIGITS)
//   data    : write data
//   ack     : write acknowledge, one cycle after sel
//   rd_data : registered read-back data (only with SEG7_READBACK_EN defined)
// ---------------------------------------------------------------------------
interface seg7_mmio_display_if #(
  parameter int ADDR_W = 4
);
  import seg7_pkg::*;

  logic              sel;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              ack;
`ifdef SEG7_READBACK_EN
  logic [DATA_W-1:0] rd_data;
`endif

  modport master (
    output sel, addr, data,
`ifdef SEG7_READBACK_EN
    input  rd_data,
`endif
    input  ack
  );

  modport slave (
    input  sel, addr, data,
`ifdef SEG7_READBACK_EN
    output rd_data,
`endif
    output ack
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// ---------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex nibble to active-high 7-segment pattern.
//   nibble : 4-bit value 0..F
//   seg    : segments, bit 0 = a ... bit 6 = g, 1 = lit
// ---------------------------------------------------------------------------
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_mmio_display.sv
// ---------------------------------------------------------------------------
// seg7_mmio_display
// Memory-mapped 7-segment display controller with NUM_DIGITS digit
// registers and one control register (global blank + blink rate).
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : seg7_mmio_display_if.slave register bus
//   hex  : active-low segments, hex[7k+6:7k] = digit k, bit 0 = segment a
// Optional build macro SEG7_READBACK_EN adds the registered rd_data path.
// ---------------------------------------------------------------------------
module seg7_mmio_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 4,
  parameter int PRESCALE_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  seg7_mmio_display_if.slave      bus,
  output logic [7*NUM_DIGITS-1:0] hex
);

  logic [DATA_W-1:0]     digit_q [NUM_DIGITS];
  ctrl_t                 ctrl_q;
  logic [PRESCALE_W-1:0] cnt;
  logic [7*NUM_DIGITS-1:0] seg_all;
  logic [7:0]            cnt_top;
  logic                  phase;

  // Register file. Out-of-range addresses match nothing and are swallowed.
  // NOTE: these are a handful of flops, not a RAM, so every entry is reset
  // to give a defined display from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
      ctrl_q <= '0;
    end else if (bus.sel) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (bus.addr == ADDR_W'(k)) digit_q[k] <= bus.data;
      end
      if (bus.addr == ADDR_W'(NUM_DIGITS)) ctrl_q <= ctrl_t'(bus.data[CTRL_W-1:0]);
    end
  end

  // Every write, in range or not, is acknowledged so the bus cannot hang.
  // NOTE: non-blocking assignments keep all flops sampling pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.ack <= 1'b0;
    else     bus.ack <= bus.sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt + 1'b1;
  end

  // Rate R picks cnt[PRESCALE_W-1-R]; R=0 is the MSB (slowest blink).
  assign cnt_top = cnt[PRESCALE_W-1 -: 8];
  assign phase   = cnt_top[3'd7 - ctrl_q.rate];

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] dec_seg;
    logic [6:0] src_seg;

    seg7_hex_decode u_dec (
      .nibble (digit_q[k][NIBBLE_MSB:0]),
      .seg    (dec_seg)
    );

    assign src_seg = digit_q[k][HEX_BIT] ? dec_seg : digit_q[k][SEG_MSB:0];
    assign seg_all[7*k +: 7] =
      (ctrl_q.blank || (digit_q[k][BLINK_BIT] && phase)) ? 7'h00 : src_seg;
  end

  // Registered, inverted for the active-low board segments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hex <= '1;
    else     hex <= ~seg_all;
  end

`ifdef SEG7_READBACK_EN
  logic [DATA_W-1:0] rd_next;

  // NOTE: the default first assignment keeps this block free of latches.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bus.addr == ADDR_W'(k)) rd_next = digit_q[k];
    end
    if (bus.addr == ADDR_W'(NUM_DIGITS)) rd_next = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bus.rd_data <= '0;
    else     bus.rd_data <= rd_next;
  end
`endif

endmodule

// File: tb/tb_seg7_mmio_display.sv
// ---------------------------------------------------------------------------
// tb_seg7_mmio_display
// Self-checking bench for seg7_mmio_display (NUM_DIGITS=6, ADDR_W=4,
// PRESCALE_W=8). Directed write vectors from a table, then hand-written
// sequences for back-to-back writes, blank, blink rates, asynchronous reset
// and (with SEG7_READBACK_EN) read-back.
// ---------------------------------------------------------------------------
module tb_seg7_mmio_display;
  import seg7_pkg::*;

  localparam int NUM_DIGITS = 6;
  localparam int ADDR_W     = 4;
  localparam int PRESCALE_W = 8;
  localparam int HEX_W      = 7 * NUM_DIGITS;

  logic             clk;
  logic             rst;
  logic [HEX_W-1:0] hex;
  logic [7:0]       m_cnt;
  logic [HEX_W-1:0] exp_full;
  int               tests;
  int               fails;

  seg7_mmio_display_if #(.ADDR_W(ADDR_W)) bus ();

  seg7_mmio_display #(
    .NUM_DIGITS (NUM_DIGITS),
    .ADDR_W     (ADDR_W),
    .PRESCALE_W (PRESCALE_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .hex (hex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent model of the free-running prescaler.
  always @(posedge clk or posedge rst) begin
    if (rst) m_cnt <= 8'd0;
    else     m_cnt <= m_cnt + 8'd1;
  end

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [8:0]        data;
    int                digit;   // -1: no digit expected to change
    logic [6:0]        exp_hex; // active-low pattern for that digit
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [8:0] d);
    @(posedge clk); #1;
    bus.sel  = 1'b1;
    bus.addr = a;
    bus.data = d;
    @(posedge clk); #1;
    bus.sel  = 1'b0;
  endtask

  // Blink phase the DUT used for the HEX value visible now (cnt before last edge).
  function automatic logic exp_phase(input logic [2:0] r);
    logic [7:0] pc;
    pc = m_cnt - 8'd1;
    return pc[3'd7 - r];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    tests    = 0;
    fails    = 0;
    exp_full = '1;

    vecs[0]  = '{addr: 4'd2,  data: 9'h07F, digit: 2,  exp_hex: 7'h00};
    vecs[1]  = '{addr: 4'd0,  data: 9'h08A, digit: 0,  exp_hex: 7'h08};
    vecs[2]  = '{addr: 4'd1,  data: 9'h080, digit: 1,  exp_hex: 7'h40};
    vecs[3]  = '{addr: 4'd3,  data: 9'h086, digit: 3,  exp_hex: 7'h02};
    vecs[4]  = '{addr: 4'd4,  data: 9'h08B, digit: 4,  exp_hex: 7'h03};
    vecs[5]  = '{addr: 4'd5,  data: 9'h08F, digit: 5,  exp_hex: 7'h0E};
    vecs[6]  = '{addr: 4'd5,  data: 9'h0F5, digit: 5,  exp_hex: 7'h12};
    vecs[7]  = '{addr: 4'd0,  data: 9'h055, digit: 0,  exp_hex: 7'h2A};
    vecs[8]  = '{addr: 4'd1,  data: 9'h100, digit: 1,  exp_hex: 7'h7F};
    vecs[9]  = '{addr: 4'd15, data: 9'h07F, digit: -1, exp_hex: 7'h00};
    vecs[10] = '{addr: 4'd7,  data: 9'h1FF, digit: -1, exp_hex: 7'h00};
    vecs[11] = '{addr: 4'd1,  data: 9'h000, digit: 1,  exp_hex: 7'h7F};

    // Reset state
    rst      = 1'b1;
    bus.sel  = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    #1;
    check("reset_hex", 64'(hex), 64'(exp_full));
    check("reset_ack", 64'(bus.ack), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_hex", 64'(hex), 64'(exp_full));

    // Table-driven writes
    for (int i = 0; i < 12; i++) begin
      do_write(vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), 64'(bus.ack), 64'd1);
      if (vecs[i].digit >= 0) exp_full[7*vecs[i].digit +: 7] = vecs[i].exp_hex;
      @(negedge clk);
      check($sformatf("vec%0d_hex", i), 64'(hex), 64'(exp_full));
      check($sformatf("vec%0d_ack_clear", i), 64'(bus.ack), 64'd0);
    end

    // Global blank, then an out-of-range write while blanked
    do_write(4'd6, 9'h001);
    @(negedge clk);
    check("blank_ack", 64'(bus.ack), 64'd1);
    @(negedge clk);
    check("blank_hex", 64'(hex), {64{1'b1}} >> (64 - HEX_W));
    do_write(4'd15, 9'h000);
    @(negedge clk);
    check("oor_ack", 64'(bus.ack), 64'd1);
    @(negedge clk);
    check("oor_blank_hex", 64'(hex), {64{1'b1}} >> (64 - HEX_W));
    do_write(4'd6, 9'h000);
    @(negedge clk);
    @(negedge clk);
    check("unblank_hex", 64'(hex), 64'(exp_full));

    // Back-to-back writes: each gets its own ack
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.addr = 4'd4; bus.data = 9'h080;
    @(posedge clk); #1;
    bus.addr = 4'd5; bus.data = 9'h081;
    @(negedge clk);
    check("b2b_ack1", 64'(bus.ack), 64'd1);
    @(posedge clk); #1;
    bus.sel = 1'b0;
    @(negedge clk);
    check("b2b_ack2", 64'(bus.ack), 64'd1);
    exp_full[28 +: 7] = 7'h40;
    check("b2b_hex1", 64'(hex), 64'(exp_full));
    @(negedge clk);
    check("b2b_ack_clear", 64'(bus.ack), 64'd0);
    exp_full[35 +: 7] = 7'h79;
    check("b2b_hex2", 64'(hex), 64'(exp_full));

    // Blink, fastest rate: phase = cnt[0]
    do_write(4'd1, 9'h17F);
    do_write(4'd6, 9'h00E);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("blink_r7_%0d", i), 64'(hex[13:7]),
            exp_phase(3'd7) ? 64'h7F : 64'h00);
    end

    // Blink, slowest rate: phase = cnt[7]
    do_write(4'd6, 9'h000);
    @(negedge clk);
    for (int i = 0; i < 34; i++) begin
      repeat (8) @(negedge clk);
      check($sformatf("blink_r0_%0d", i), 64'(hex[13:7]),
            exp_phase(3'd0) ? 64'h7F : 64'h00);
    end

    // Asynchronous reset mid-write, between clock edges
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.addr = 4'd0; bus.data = 9'h07F;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_hex", 64'(hex), {64{1'b1}} >> (64 - HEX_W));
    check("async_rst_ack", 64'(bus.ack), 64'd0);
    check("async_rst_cnt", 64'(dut.cnt), 64'd0);
    @(posedge clk); #1;
    check("rst_sel_dropped_ack", 64'(bus.ack), 64'd0);
`ifdef SEG7_READBACK_EN
    check("rst_rd_data", 64'(bus.rd_data), 64'd0);
`endif
    bus.sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_rst_hex", 64'(hex), {64{1'b1}} >> (64 - HEX_W));
    check("after_rst_ack", 64'(bus.ack), 64'd0);

`ifdef SEG7_READBACK_EN
    // Read-back: one-cycle registered path driven by addr
    do_write(4'd3, 9'h1A5);
    bus.addr = 4'd3;
    @(negedge clk);
    @(negedge clk);
    check("rd_digit3", 64'(bus.rd_data), 64'h1A5);
    do_write(4'd6, 9'h00B);
    bus.addr = 4'd6;
    @(negedge clk);
    @(negedge clk);
    check("rd_ctrl", 64'(bus.rd_data), 64'h00B);
    @(posedge clk); #1;
    bus.addr = 4'd15;
    @(negedge clk);
    check("rd_oor", 64'(bus.rd_data), 64'h000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
